// File: rtl/fpga2host_arbiter_pkg.sv
// Shared definitions for the fpga2host packet arbiter: FSM state encoding,
// the word emitted when the stall watchdog aborts a packet, and the depth of
// the outbound FIFO that the room check is measured against.
package fpga2host_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam int          FIFO_DEPTH = 512;
    localparam logic [31:0] ABORT_WORD = 32'hDEAD_0000;

endpackage

// File: rtl/fpga2host_arbiter_rr_select.sv
// Combinational round-robin picker: scans the request vector starting at the
// pointer position and returns a one-hot grant for the first requester found.
module fpga2host_arbiter_rr_select #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [IW-1:0] idx;
    logic          found;

    // First requester at or after ptr (wrapping) wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpga2host_arbiter.sv
// Packet arbiter merging NUM_SRC source streams onto the fpga2host stream.
// Source 0 (command responses) has strict priority and skips the FIFO room
// check; sources 1..NUM_SRC-1 are served round-robin and only start when the
// outbound FIFO has at least MIN_ROOM free words. Ownership changes only at
// packet boundaries.
//
// Handshake: a beat transfers on a cycle where valid and ready are both high;
// valid never depends on ready, and data/last are only meaningful while valid.
//
// Build option: define FPGA2HOST_ARB_WATCHDOG_EN to add a mid-packet stall
// watchdog that terminates a stalled packet with an abort word after
// WD_CYCLES idle cycles from the granted source.
module fpga2host_arbiter
    import fpga2host_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = 3,
    parameter int MIN_ROOM  = 64,
    parameter int WD_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0][31:0]   s_tdata,
    input  logic [NUM_SRC-1:0]         s_tvalid,
    input  logic [NUM_SRC-1:0]         s_tlast,
    output logic [NUM_SRC-1:0]         s_tready,
    output logic [31:0]                m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    input  logic                       m_tready,
    input  logic [9:0]                 fpga2host_fifo_filled,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_wd_pulse
);

    localparam int IW = $clog2(NUM_SRC);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic [9:0]         fill_sat;
    logic               room_ok;
    logic [NUM_SRC-1:0] rr_req;
    logic [NUM_SRC-1:0] rr_grant;
    logic [IW-1:0]      rr_idx;
    logic               rr_any;
    logic               last_hs;
    logic               wd_expire;

    // Free room in the outbound FIFO; fill levels above the depth count as full.
    always_comb begin
        fill_sat = (fpga2host_fifo_filled > 10'(FIFO_DEPTH)) ? 10'(FIFO_DEPTH) : fpga2host_fifo_filled;
        room_ok  = (FIFO_DEPTH - int'(fill_sat)) >= MIN_ROOM;
        rr_req   = s_tvalid & {{(NUM_SRC-1){room_ok}}, 1'b0};
    end

    fpga2host_arbiter_rr_select #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_rr_select (
        .req   (rr_req),
        .ptr   (rr_ptr_q),
        .grant (rr_grant)
    );

    // One-hot round-robin grant to a source index.
    always_comb begin
        rr_idx = '0;
        rr_any = |rr_grant;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rr_grant[i]) rr_idx = IW'(i);
        end
    end

    assign last_hs = (state_q == ST_XFER) && s_tvalid[grant_q] && s_tlast[grant_q] && m_tready;

`ifdef FPGA2HOST_ARB_WATCHDOG_EN
    logic [$clog2(WD_CYCLES+1)-1:0] wd_cnt_q;
    logic                           err_wd_q;

    assign wd_expire = (state_q == ST_XFER) && !s_tvalid[grant_q] && (int'(wd_cnt_q) == WD_CYCLES - 1);

    // Stall counter: restarts on every accepted beat, counts cycles the owner is not valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            err_wd_q <= 1'b0;
        end else begin
            if (state_q != ST_XFER || (s_tvalid[grant_q] && m_tready)) begin
                wd_cnt_q <= '0;
            end else if (!s_tvalid[grant_q]) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            err_wd_q <= (state_q == ST_ABORT) && m_tready;
        end
    end

    assign err_wd_pulse = err_wd_q;
`else
    logic unused_wd_cfg;

    // Watchdog configuration stays referenced in builds without the watchdog.
    assign unused_wd_cfg = ^{32'(WD_CYCLES), ABORT_WORD};
    assign wd_expire     = 1'b0;
    assign err_wd_pulse  = 1'b0;
`endif

    // Next-state, grant, pointer and output mux.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        case (state_q)
            ST_IDLE: begin
                if (s_tvalid[0]) begin
                    state_d = ST_XFER;
                    grant_d = '0;
                end else if (rr_any) begin
                    state_d = ST_XFER;
                    grant_d = rr_idx;
                end
            end
            ST_XFER: begin
                m_tdata           = s_tdata[grant_q];
                m_tvalid          = s_tvalid[grant_q];
                m_tlast           = s_tlast[grant_q];
                s_tready[grant_q] = m_tready;
                if (last_hs) begin
                    state_d = ST_IDLE;
                    // Only data sources advance the rotation; source 0 is outside it.
                    if (grant_q != '0) begin
                        rr_ptr_d = (grant_q == IW'(NUM_SRC - 1)) ? IW'(1) : grant_q + 1'b1;
                    end
                end else if (wd_expire) begin
                    state_d = ST_ABORT;
                end
            end
`ifdef FPGA2HOST_ARB_WATCHDOG_EN
            ST_ABORT: begin
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                m_tdata  = ABORT_WORD | 32'(grant_q);
                if (m_tready) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= IW'(1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpga2host_arbiter.sv
// Testbench for fpga2host_arbiter: cycle-by-cycle vector table plus directed
// sequences for ready toggling, mid-packet reset and mid-packet stall.
module tb_fpga2host_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0][31:0] s_tdata;
    logic [2:0]       s_tvalid, s_tlast, s_tready;
    logic [31:0]      m_tdata;
    logic             m_tvalid, m_tlast, m_tready;
    logic [9:0]       filled;
    logic [1:0]       grant_id;
    logic             busy, err_wd_pulse;

    fpga2host_arbiter #(
        .NUM_SRC   (3),
        .MIN_ROOM  (64),
        .WD_CYCLES (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .s_tdata               (s_tdata),
        .s_tvalid              (s_tvalid),
        .s_tlast               (s_tlast),
        .s_tready              (s_tready),
        .m_tdata               (m_tdata),
        .m_tvalid              (m_tvalid),
        .m_tlast               (m_tlast),
        .m_tready              (m_tready),
        .fpga2host_fifo_filled (filled),
        .grant_id              (grant_id),
        .busy                  (busy),
        .err_wd_pulse          (err_wd_pulse)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  vld;
        logic [2:0]  lst;
        logic [23:0] d;
        logic [9:0]  fill;
        logic        e_mv;
        logic [31:0] e_md;
        logic        e_ml;
        logic [2:0]  e_srdy;
        logic [1:0]  e_gid;
        logic        e_busy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [2:0] vld, input logic [2:0] lst, input int d,
                                input int fill, input logic mv, input logic [31:0] md,
                                input logic ml, input logic [2:0] srdy, input int gid,
                                input logic bsy);
        vec_t v;
        v.vld    = vld;
        v.lst    = lst;
        v.d      = 24'(d);
        v.fill   = 10'(fill);
        v.e_mv   = mv;
        v.e_md   = md;
        v.e_ml   = ml;
        v.e_srdy = srdy;
        v.e_gid  = 2'(gid);
        v.e_busy = bsy;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // Source k presents {k, d} so the owner is visible in the merged data.
    task automatic drive_src(input logic [2:0] vld, input logic [2:0] lst, input logic [23:0] d);
        s_tvalid = vld;
        s_tlast  = lst;
        for (int k = 0; k < 3; k++) s_tdata[k] = {8'(k), d};
    endtask

    task automatic drive_one(input logic [31:0] data, input logic vld, input logic lst);
        s_tvalid    = {1'b0, vld, 1'b0};
        s_tlast     = {1'b0, lst, 1'b0};
        s_tdata[1]  = data;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] words[4];
        logic [31:0] e;
        int idx, got, stall;
        logic hs;

        // ---------------- reset ----------------
        rst      = 1'b1;
        m_tready = 1'b1;
        filled   = '0;
        drive_src(3'b111, 3'b111, 24'h5);
        repeat (2) @(negedge clk);
        check("rst.m_tvalid", 32'(m_tvalid), 32'h0);
        check("rst.m_tlast",  32'(m_tlast),  32'h0);
        check("rst.m_tdata",  m_tdata,       32'h0);
        check("rst.s_tready", 32'(s_tready), 32'h0);
        check("rst.grant_id", 32'(grant_id), 32'h0);
        check("rst.busy",     32'(busy),     32'h0);
        check("rst.err_wd",   32'(err_wd_pulse), 32'h0);
        drive_src(3'b000, 3'b000, 24'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        // single 3-word packet from source 1
        vq.push_back(mk(3'b010, 3'b000, 1, 0,   0, 32'h0,        0, 3'b000, 0, 0));
        vq.push_back(mk(3'b010, 3'b000, 1, 0,   1, 32'h01000001, 0, 3'b010, 1, 1));
        vq.push_back(mk(3'b010, 3'b000, 2, 0,   1, 32'h01000002, 0, 3'b010, 1, 1));
        vq.push_back(mk(3'b010, 3'b010, 3, 0,   1, 32'h01000003, 1, 3'b010, 1, 1));
        vq.push_back(mk(3'b000, 3'b000, 0, 0,   0, 32'h0,        0, 3'b000, 1, 0));
        // sources 1 and 2 continuously valid, 2-word packets alternate
        vq.push_back(mk(3'b110, 3'b000, 1, 0,   0, 32'h0,        0, 3'b000, 1, 0));
        vq.push_back(mk(3'b110, 3'b000, 1, 0,   1, 32'h02000001, 0, 3'b100, 2, 1));
        vq.push_back(mk(3'b110, 3'b100, 2, 0,   1, 32'h02000002, 1, 3'b100, 2, 1));
        vq.push_back(mk(3'b110, 3'b000, 1, 0,   0, 32'h0,        0, 3'b000, 2, 0));
        vq.push_back(mk(3'b110, 3'b000, 1, 0,   1, 32'h01000001, 0, 3'b010, 1, 1));
        vq.push_back(mk(3'b110, 3'b010, 2, 0,   1, 32'h01000002, 1, 3'b010, 1, 1));
        vq.push_back(mk(3'b110, 3'b000, 1, 0,   0, 32'h0,        0, 3'b000, 1, 0));
        vq.push_back(mk(3'b110, 3'b000, 1, 0,   1, 32'h02000001, 0, 3'b100, 2, 1));
        vq.push_back(mk(3'b110, 3'b100, 2, 0,   1, 32'h02000002, 1, 3'b100, 2, 1));
        vq.push_back(mk(3'b000, 3'b000, 0, 0,   0, 32'h0,        0, 3'b000, 2, 0));
        // room check: 52 free blocks source 1, source 0 unaffected, 64 free allows
        vq.push_back(mk(3'b010, 3'b000, 1, 460, 0, 32'h0,        0, 3'b000, 2, 0));
        vq.push_back(mk(3'b010, 3'b000, 1, 460, 0, 32'h0,        0, 3'b000, 2, 0));
        vq.push_back(mk(3'b011, 3'b001, 5, 460, 0, 32'h0,        0, 3'b000, 2, 0));
        vq.push_back(mk(3'b011, 3'b001, 5, 460, 1, 32'h00000005, 1, 3'b001, 0, 1));
        vq.push_back(mk(3'b010, 3'b000, 1, 460, 0, 32'h0,        0, 3'b000, 0, 0));
        vq.push_back(mk(3'b010, 3'b000, 7, 448, 0, 32'h0,        0, 3'b000, 0, 0));
        vq.push_back(mk(3'b010, 3'b010, 7, 448, 1, 32'h01000007, 1, 3'b010, 1, 1));
        vq.push_back(mk(3'b000, 3'b000, 0, 0,   0, 32'h0,        0, 3'b000, 1, 0));
        // fill above depth means no room
        vq.push_back(mk(3'b010, 3'b000, 1, 600, 0, 32'h0,        0, 3'b000, 1, 0));
        vq.push_back(mk(3'b000, 3'b000, 0, 0,   0, 32'h0,        0, 3'b000, 1, 0));
        // source 0 arrives during a source 2 packet, then rotation resumes
        vq.push_back(mk(3'b110, 3'b000, 1, 0,   0, 32'h0,        0, 3'b000, 1, 0));
        vq.push_back(mk(3'b110, 3'b000, 1, 0,   1, 32'h02000001, 0, 3'b100, 2, 1));
        vq.push_back(mk(3'b111, 3'b100, 2, 0,   1, 32'h02000002, 1, 3'b100, 2, 1));
        vq.push_back(mk(3'b111, 3'b000, 1, 0,   0, 32'h0,        0, 3'b000, 2, 0));
        vq.push_back(mk(3'b111, 3'b001, 9, 0,   1, 32'h00000009, 1, 3'b001, 0, 1));
        vq.push_back(mk(3'b110, 3'b000, 1, 0,   0, 32'h0,        0, 3'b000, 0, 0));
        vq.push_back(mk(3'b110, 3'b010, 3, 0,   1, 32'h01000003, 1, 3'b010, 1, 1));
        // source 0 packet must not move the rotation away from source 2
        vq.push_back(mk(3'b001, 3'b001, 4, 0,   0, 32'h0,        0, 3'b000, 1, 0));
        vq.push_back(mk(3'b001, 3'b001, 4, 0,   1, 32'h00000004, 1, 3'b001, 0, 1));
        vq.push_back(mk(3'b110, 3'b000, 1, 0,   0, 32'h0,        0, 3'b000, 0, 0));
        vq.push_back(mk(3'b110, 3'b100, 6, 0,   1, 32'h02000006, 1, 3'b100, 2, 1));
        vq.push_back(mk(3'b000, 3'b000, 0, 0,   0, 32'h0,        0, 3'b000, 2, 0));

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            drive_src(vq[i].vld, vq[i].lst, vq[i].d);
            filled   = vq[i].fill;
            m_tready = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d.m_tvalid", i), 32'(m_tvalid), 32'(vq[i].e_mv));
            check($sformatf("v%0d.m_tdata", i),  m_tdata,       vq[i].e_md);
            check($sformatf("v%0d.m_tlast", i),  32'(m_tlast),  32'(vq[i].e_ml));
            check($sformatf("v%0d.s_tready", i), 32'(s_tready), 32'(vq[i].e_srdy));
            check($sformatf("v%0d.grant_id", i), 32'(grant_id), 32'(vq[i].e_gid));
            check($sformatf("v%0d.busy", i),     32'(busy),     32'(vq[i].e_busy));
        end

        // ---------------- m_tready toggling on a 4-word packet ----------------
        words = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
        for (int k = 0; k < 4; k++) exp_q.push_back(words[k]);
        idx = 0;
        got = 0;
        hs  = 1'b0;
        m_tready = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(posedge clk); #1;
            if (hs) idx++;
            if (idx < 4) drive_one(words[idx], 1'b1, idx == 3);
            else         drive_one(32'h0, 1'b0, 1'b0);
            m_tready = ~m_tready;
            @(negedge clk);
            hs = s_tready[1] && s_tvalid[1];
            if (m_tvalid && m_tready) begin
                got++;
                if (exp_q.size() == 0) begin
                    check("tog.extra_beat", m_tdata, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("tog.data", m_tdata, e);
                    check("tog.last", 32'(m_tlast), 32'(got == 4));
                end
            end
        end
        check("tog.beats", 32'(got), 32'd4);
        @(posedge clk); #1;
        drive_one(32'h0, 1'b0, 1'b0);
        m_tready = 1'b1;
        @(negedge clk);
        check("tog.after_valid", 32'(m_tvalid), 32'h0);
        check("tog.after_busy",  32'(busy),     32'h0);

        // ---------------- reset in the middle of a packet ----------------
        @(posedge clk); #1;
        drive_one(32'hB000_0001, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mrst.pre_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mrst.m_tvalid", 32'(m_tvalid), 32'h0);
        check("mrst.m_tlast",  32'(m_tlast),  32'h0);
        check("mrst.s_tready", 32'(s_tready), 32'h0);
        check("mrst.busy",     32'(busy),     32'h0);
        check("mrst.grant_id", 32'(grant_id), 32'h0);
        drive_one(32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- stall after word 2 ----------------
        @(posedge clk); #1;
        drive_one(32'hC000_0001, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall.w1", m_tdata, 32'hC000_0001);
        @(posedge clk); #1;
        drive_one(32'hC000_0002, 1'b1, 1'b0);
        @(negedge clk);
        check("stall.w2", m_tdata, 32'hC000_0002);
        @(posedge clk); #1;
        drive_one(32'h0, 1'b0, 1'b0);
`ifdef FPGA2HOST_ARB_WATCHDOG_EN
        stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_tvalid) break;
            stall++;
            @(posedge clk); #1;
        end
        check("wd.stall_cycles", 32'(stall),  32'd16);
        check("wd.abort_word",   m_tdata,     32'hDEAD_0001);
        check("wd.abort_last",   32'(m_tlast), 32'h1);
        check("wd.s_tready",     32'(s_tready), 32'h0);
        @(negedge clk);
        check("wd.pulse",        32'(err_wd_pulse), 32'h1);
        check("wd.idle",         32'(busy),     32'h0);
        @(negedge clk);
        check("wd.pulse_end",    32'(err_wd_pulse), 32'h0);
`else
        stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy && !m_tvalid) stall++;
        end
        check("stall.cycles",   32'(stall),    32'd40);
        check("stall.busy",     32'(busy),     32'h1);
        check("stall.s_tready", 32'(s_tready), 32'b010);
        check("stall.err_wd",   32'(err_wd_pulse), 32'h0);
        @(posedge clk); #1;
        drive_one(32'hC000_0003, 1'b1, 1'b1);
        @(negedge clk);
        check("stall.w3",      m_tdata,      32'hC000_0003);
        check("stall.w3_last", 32'(m_tlast), 32'h1);
        @(posedge clk); #1;
        drive_one(32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("stall.done", 32'(busy), 32'h0);
`endif

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpga2host_arbiter.md
FPGA2HOST_ARBITER -- requirements
Module: fpga2host_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 3: number of packet sources; source 0 is the command-response source.
REQ-002 Parameter MIN_ROOM, default 64: minimum free words in the outbound FIFO before a packet from source 1..NUM_SRC-1 may start.
REQ-003 Parameter WD_CYCLES, default 1024: mid-packet stall limit used by the watchdog.
REQ-004 Port clk  input  1  single clock for all logic.
REQ-005 Port rst  input  1  reset; asynchronous, active-high.
REQ-006 Ports s_tdata/s_tvalid/s_tlast  input  NUM_SRC x 32 / NUM_SRC / NUM_SRC  source streams.
REQ-007 Port s_tready  output  NUM_SRC  per-source ready.
REQ-008 Ports m_tdata/m_tvalid/m_tlast  output  32/1/1  merged stream to spi_interface fpga2host side.
REQ-009 Port m_tready  input  1  downstream ready.
REQ-010 Port fpga2host_fifo_filled  input  10  outbound FIFO fill level, 0-512.
REQ-011 Port grant_id  output  $clog2(NUM_SRC)  source currently owning the output.
REQ-012 Port busy  output  1  high while a packet is in transfer.
REQ-013 Port err_wd_pulse  output  1  one-cycle pulse on watchdog abort (tied 0 when macro absent).

Function
REQ-014 Arbitration SHALL occur only at packet boundaries; a granted source keeps the output until its tlast beat handshakes.
REQ-015 States: IDLE, XFER, ABORT (ABORT exists only with the watchdog macro).
REQ-016 IDLE: if s_tvalid[0], grant source 0; else round-robin among eligible sources 1..NUM_SRC-1, starting after the last-granted one.
REQ-017 Source k>=1 is eligible only if s_tvalid[k] and (512 - fpga2host_fifo_filled) >= MIN_ROOM; source 0 ignores the room check.
REQ-018 Grant is registered: IDLE->XFER on the cycle after a valid request; grant_id and busy update on that edge; first beat may pass in the first XFER cycle.
REQ-019 XFER: m_tdata/m_tvalid/m_tlast combinationally follow the granted source; s_tready[grant_id] = m_tready; all other s_tready = 0.
REQ-020 XFER->IDLE on the edge where m_tvalid & m_tready & m_tlast; one idle bubble cycle follows every packet.
REQ-021 In IDLE all s_tready = 0, m_tvalid = 0.
REQ-022 Round-robin pointer SHALL advance only when a source >=1 completes a packet; source 0 packets do not move it.
REQ-023 Single-beat packets (tvalid with tlast on the first beat) SHALL be handled identically.
REQ-024 Fill level above 512 SHALL be treated as 512 (zero room).

Reset
REQ-025 During reset: state IDLE, grant_id 0, busy 0, m_tvalid 0, m_tlast 0, m_tdata 0, all s_tready 0, err_wd_pulse 0, round-robin pointer selects source 1 first.
REQ-026 Reset asserted mid-packet SHALL drop the packet immediately; no tlast is generated.

Configuration
REQ-027 Macro FPGA2HOST_ARB_WATCHDOG_EN compiles in the stall watchdog.
REQ-028 With macro: counter clears on every XFER handshake, increments in XFER while s_tvalid[grant_id] = 0; reaching WD_CYCLES enters ABORT.
REQ-029 ABORT: drive m_tvalid=1, m_tlast=1, m_tdata=32'hDEAD_0000|grant_id, s_tready all 0; on handshake pulse err_wd_pulse one cycle, go IDLE; stalled source is then expected to reissue from packet start.
REQ-030 Without macro: no counter, no ABORT, err_wd_pulse constant 0, stalls last indefinitely.

Structure
REQ-031 Shared package holds the state enum, abort-word constant, and FIFO depth constant 512.
REQ-032 One sub-module, rr_select: combinational round-robin picker (request vector, pointer -> one-hot grant).

Verification
REQ-033 Source 1 sends 3-word packet {1,2,3}, filled=0 -> m stream {1,2,3} with tlast on 3, grant_id=1, busy high 3 cycles when m_tready=1.
REQ-034 Sources 1 and 2 both valid continuously, 2-word packets -> output alternates 1,2,1,2 packet-wise, never interleaved words.
REQ-035 Source 0 raises valid mid-packet of source 2 -> source 2 packet completes, then source 0 packet, then source 1/2 resume RR.
REQ-036 filled=460 (room 52), source 1 valid -> no grant; source 0 valid -> granted; filled=448 -> source 1 granted.
REQ-037 m_tready toggling 1-0 every cycle on 4-word packet -> all 4 words delivered in order, no duplicates.
REQ-038 With FPGA2HOST_ARB_WATCHDOG_EN, WD_CYCLES=16, source 1 drops valid after word 2 -> after 16 cycles m word 32'hDEAD_0001 with tlast, err_wd_pulse one cycle, state IDLE.
